// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the divided-clock monitor.
// Holds the FSM encoding and the timeout threshold function.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArm    = 2'd1,
    StMeas   = 2'd2,
    StLocked = 2'd3
  } mon_state_e;

  localparam int unsigned TIMEOUT_MARGIN = 4;

  function automatic int unsigned to_timeout(input int unsigned ratio);
    return 2 * ratio + TIMEOUT_MARGIN;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level, with registered rise/fall pulses.
// o_sync is the delayed level aligned with the pulses.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_level;

  assign w_level = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= w_level;
      r_rise <= w_level & ~r_prev;
      r_fall <= ~w_level & r_prev;
    end
  end

  assign o_sync = r_prev;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures a looped-back divided clock against i_ref_clk and reports lock/error/timeout.
// Define CLKMON_DUTY_CHECK_EN to also require the high time to equal i_exp_ratio>>1.
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned LOCK_CNT    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             i_ref_clk,
  input  logic             i_rst_n,
  input  logic             i_mon_en,
  input  logic             i_mon_clk,
  input  logic [WIDTH-1:0] i_exp_ratio,
  output logic [WIDTH+1:0] o_period,
  output logic [WIDTH+1:0] o_high,
  output logic             o_meas_valid,
  output logic             o_locked,
  output logic             o_err,
  output logic             o_timeout
);

  localparam int unsigned CW = WIDTH + 2;
  localparam int unsigned MW = 4;

  logic w_sync, w_rise, w_fall, w_unused_edges;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .i_clk  (i_ref_clk),
    .i_rst_n(i_rst_n),
    .i_async(i_mon_clk),
    .o_sync (w_sync),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  mon_state_e       r_state, w_state_d;
  logic [CW-1:0]    r_cnt_per, w_cnt_per_d, w_thr, r_period;
  logic [WIDTH-1:0] r_exp;
  logic [MW-1:0]    r_match, w_match_d;
  logic             r_locked, w_locked_d, r_err, w_err_d, r_timeout, w_timeout_d;
  logic             r_meas_valid, w_capture;
  logic             w_ratio_ok, w_ratio_chg, w_per_ok, w_match, w_to_hit;

  assign w_ratio_ok  = i_exp_ratio > WIDTH'(1);
  assign w_ratio_chg = i_exp_ratio != r_exp;
  assign w_thr       = CW'(to_timeout(32'(i_exp_ratio)));
  assign w_per_ok    = r_cnt_per == CW'(i_exp_ratio);
  assign w_to_hit    = r_cnt_per >= w_thr;

  // Period counter: cleared in idle, restarts at 1 on each rise, saturates.
  always_comb begin
    w_cnt_per_d = r_cnt_per;
    if (r_state == StIdle) begin
      w_cnt_per_d = '0;
    end else if (w_rise) begin
      w_cnt_per_d = CW'(1);
    end else if (r_cnt_per != '1) begin
      w_cnt_per_d = r_cnt_per + CW'(1);
    end
  end

`ifdef CLKMON_DUTY_CHECK_EN
  logic [CW-1:0] r_cnt_hi, w_cnt_hi_d, r_high;

  always_comb begin
    w_cnt_hi_d = r_cnt_hi;
    if (r_state == StIdle) begin
      w_cnt_hi_d = '0;
    end else if (w_rise) begin
      w_cnt_hi_d = CW'(1);
    end else if (w_sync && (r_cnt_hi != '1)) begin
      w_cnt_hi_d = r_cnt_hi + CW'(1);
    end
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt_hi <= '0;
      r_high   <= '0;
    end else begin
      r_cnt_hi <= w_cnt_hi_d;
      if (w_capture) r_high <= r_cnt_hi;
    end
  end

  assign w_match        = w_per_ok && (r_cnt_hi == CW'(i_exp_ratio >> 1));
  assign o_high         = r_high;
  assign w_unused_edges = w_fall;
`else
  assign w_match        = w_per_ok;
  assign o_high         = '0;
  assign w_unused_edges = w_fall ^ w_sync;
`endif

  // Priority: disable/invalid ratio, ratio change, rise, timeout.
  always_comb begin
    w_state_d   = r_state;
    w_match_d   = r_match;
    w_locked_d  = r_locked;
    w_err_d     = r_err;
    w_timeout_d = r_timeout;
    w_capture   = 1'b0;
    if (!i_mon_en || !w_ratio_ok) begin
      w_state_d   = StIdle;
      w_match_d   = '0;
      w_locked_d  = 1'b0;
      w_err_d     = 1'b0;
      w_timeout_d = 1'b0;
    end else if (r_state == StIdle) begin
      w_state_d = StArm;
    end else if (w_ratio_chg) begin
      w_state_d  = StArm;
      w_match_d  = '0;
      w_locked_d = 1'b0;
    end else if (w_rise) begin
      if (r_state == StArm) begin
        w_state_d = StMeas;
      end else begin
        w_capture = 1'b1;
        if (r_state == StMeas) begin
          if (!w_match) begin
            w_match_d = '0;
          end else if (r_match == MW'(LOCK_CNT - 1)) begin
            w_state_d  = StLocked;
            w_locked_d = 1'b1;
            w_match_d  = '0;
          end else begin
            w_match_d = r_match + MW'(1);
          end
        end else if (!w_match) begin
          w_state_d  = StMeas;
          w_locked_d = 1'b0;
          w_err_d    = 1'b1;
          w_match_d  = '0;
        end
      end
    end else if (w_to_hit) begin
      w_state_d   = StArm;
      w_timeout_d = 1'b1;
      w_locked_d  = 1'b0;
      w_match_d   = '0;
    end
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_cnt_per    <= '0;
      r_exp        <= '0;
      r_match      <= '0;
      r_locked     <= 1'b0;
      r_err        <= 1'b0;
      r_timeout    <= 1'b0;
      r_meas_valid <= 1'b0;
      r_period     <= '0;
    end else begin
      r_state      <= w_state_d;
      r_cnt_per    <= w_cnt_per_d;
      r_exp        <= i_exp_ratio;
      r_match      <= w_match_d;
      r_locked     <= w_locked_d;
      r_err        <= w_err_d;
      r_timeout    <= w_timeout_d;
      r_meas_valid <= w_capture;
      if (w_capture) r_period <= r_cnt_per;
    end
  end

  assign o_period     = r_period;
  assign o_meas_valid = r_meas_valid;
  assign o_locked     = r_locked;
  assign o_err        = r_err;
  assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Randomized bench for clk_div_monitor: a timestamp-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_clk_div_monitor;

  localparam int WIDTH = 4;
  localparam int LOCK  = 4;
  localparam int S     = 2;
  localparam int HN    = 65536;
`ifdef CLKMON_DUTY_CHECK_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             mon = 1'b0;
  logic [WIDTH-1:0] ratio = '0;
  logic [WIDTH+1:0] o_period, o_high;
  logic             o_meas_valid, o_locked, o_err, o_timeout;

  int n_checks = 0;
  int n_errors = 0;

  clk_div_monitor #(
    .WIDTH      (WIDTH),
    .LOCK_CNT   (LOCK),
    .SYNC_STAGES(S)
  ) dut (
    .i_ref_clk   (clk),
    .i_rst_n     (rst_n),
    .i_mon_en    (en),
    .i_mon_clk   (mon),
    .i_exp_ratio (ratio),
    .o_period    (o_period),
    .o_high      (o_high),
    .o_meas_valid(o_meas_valid),
    .o_locked    (o_locked),
    .o_err       (o_err),
    .o_timeout   (o_timeout)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: sampled input history indexed by ref-clock edge number.
  bit hist [HN];
  int m = S + 3;
  int mode = 0;      // 0 idle, 1 waiting first rise, 2 measuring, 3 locked
  int anchor = 0;    // edge index at which the period count last restarted
  int mcnt = 0;
  int prev_ratio = 0;
  bit e_locked = 0, e_err = 0, e_to = 0, e_valid = 0;
  int e_per = 0, e_hi = 0;

  task automatic model_clear();
    mode = 0; mcnt = 0; prev_ratio = 0;
    e_locked = 0; e_err = 0; e_to = 0; e_valid = 0; e_per = 0; e_hi = 0;
  endtask

  task automatic model_step();
    bit lvl, rise, was_idle, ok;
    int cnt, hi, r;
    lvl      = hist[m-1-S];
    rise     = lvl && !hist[m-2-S];
    cnt      = (m - anchor > 63) ? 63 : m - anchor;
    r        = int'(ratio);
    was_idle = (mode == 0);
    e_valid  = 0;
    if (!en || r < 2) begin
      mode = 0; mcnt = 0; e_locked = 0; e_err = 0; e_to = 0;
    end else if (mode == 0) begin
      mode = 1;
    end else if (r != prev_ratio) begin
      mode = 1; mcnt = 0; e_locked = 0;
    end else if (rise) begin
      if (mode == 1) begin
        mode = 2;
      end else begin
        hi = 0;
        for (int k = anchor; k < m; k++) if (hist[k-1-S]) hi++;
        if (hi > 63) hi = 63;
        e_valid = 1;
        e_per   = cnt;
        e_hi    = DUTY ? hi : 0;
        ok      = (cnt == r) && (!DUTY || hi == r / 2);
        if (mode == 2) begin
          if (!ok) mcnt = 0;
          else begin
            mcnt++;
            if (mcnt == LOCK) begin mode = 3; e_locked = 1; end
          end
        end else if (!ok) begin
          mode = 2; e_locked = 0; e_err = 1; mcnt = 0;
        end
      end
    end else if (cnt >= 2 * r + 4) begin
      mode = 1; e_to = 1; e_locked = 0; mcnt = 0;
    end
    if (was_idle) anchor = m + 1;
    else if (rise) anchor = m;
    prev_ratio = r;
  endtask

  initial forever begin
    @(posedge clk);
    if (m >= HN) begin
      $display("FAIL model_capacity: got %0d expected below %0d", m, HN);
      $fatal(1, "history overflow");
    end
    if (!rst_n) begin
      hist[m] = 1'b0;
      model_clear();
    end else begin
      model_step();
      hist[m] = mon;
    end
    m++;
  end

  initial forever begin
    @(negedge rst_n);
    for (int k = m - 1 - S; k < m; k++) hist[k] = 1'b0;
    model_clear();
  end

  initial forever begin
    @(negedge clk);
    chk("locked",  int'(o_locked),     int'(e_locked));
    chk("err",     int'(o_err),        int'(e_err));
    chk("timeout", int'(o_timeout),    int'(e_to));
    chk("valid",   int'(o_meas_valid), int'(e_valid));
    chk("period",  int'(o_period),     e_per);
    chk("high",    int'(o_high),       e_hi);
  end

  task automatic run_clk(input int per, input int hi, input int n);
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < per; c++) begin
        @(posedge clk); #1;
        mon = (c < hi);
      end
    end
  endtask

  task automatic hold(input bit level, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      mon = level;
    end
  endtask

  task automatic settle_check();
    hold(1'b0, 6);
    @(negedge clk);
  endtask

  int p, h, n, r;

  initial begin
    hold(1'b0, 3);
    @(negedge clk);
    chk("reset_locked", int'(o_locked), 0);
    chk("reset_period", int'(o_period), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Ratio 4, 50% duty: locks on the fifth rise.
    en = 1'b1; ratio = 4'd4;
    run_clk(4, 2, 8);
    settle_check();
    chk("t1_locked", int'(o_locked), 1);
    chk("t1_period", int'(o_period), 4);
    chk("t1_high",   int'(o_high), DUTY ? 2 : 0);
    chk("t1_err",    int'(o_err), 0);

    // Ratio 5 with 2-high locks; 3-high locks only without the duty check.
    ratio = 4'd5;
    run_clk(5, 2, 8);
    settle_check();
    chk("t2_locked", int'(o_locked), 1);
    chk("t2_period", int'(o_period), 5);
    run_clk(5, 3, 8);
    settle_check();
    chk("t2_duty_locked", int'(o_locked), DUTY ? 0 : 1);

    // Divider changes 4 -> 6 after lock: error, sticky through relock.
    ratio = 4'd4;
    run_clk(4, 2, 8);
    run_clk(6, 3, 3);
    settle_check();
    chk("t3_period", int'(o_period), 6);
    chk("t3_locked", int'(o_locked), 0);
    chk("t3_err",    int'(o_err), 1);
    run_clk(4, 2, 8);
    settle_check();
    chk("t3_relock", int'(o_locked), 1);
    chk("t3_err_held", int'(o_err), 1);
    en = 1'b0;
    hold(1'b0, 2);
    @(negedge clk);
    chk("t3_err_clr", int'(o_err), 0);

    // Stuck-low monitored clock times out; restart relocks with timeout kept.
    en = 1'b1;
    run_clk(4, 2, 8);
    hold(1'b0, 25);
    @(negedge clk);
    chk("t4_timeout", int'(o_timeout), 1);
    chk("t4_locked",  int'(o_locked), 0);
    run_clk(4, 2, 8);
    settle_check();
    chk("t4_relock",  int'(o_locked), 1);
    chk("t4_to_held", int'(o_timeout), 1);

    // Invalid ratio and disable keep status at zero; ratio change drops lock.
    ratio = 4'd1;
    run_clk(3, 1, 6);
    @(negedge clk);
    chk("t5_r1_locked", int'(o_locked), 0);
    chk("t5_r1_to",     int'(o_timeout), 0);
    en = 1'b0; ratio = 4'd4;
    run_clk(4, 2, 6);
    @(negedge clk);
    chk("t5_dis_valid", int'(o_meas_valid), 0);
    en = 1'b1;
    run_clk(4, 2, 8);
    settle_check();
    chk("t5_pre_chg", int'(o_locked), 1);
    @(posedge clk); #1;
    ratio = 4'd8;
    @(posedge clk);
    @(negedge clk);
    chk("t5_chg_unlock", int'(o_locked), 0);

    // Asynchronous reset in the middle of measuring.
    ratio = 4'd4;
    run_clk(4, 2, 8);
    run_clk(6, 3, 2);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_period", int'(o_period), 0);
    chk("t6_err",    int'(o_err), 0);
    chk("t6_to",     int'(o_timeout), 0);
    chk("t6_locked", int'(o_locked), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_clk(4, 2, 4);
    @(negedge clk);
    chk("t6_not_yet", int'(o_locked), 0);
    run_clk(4, 2, 2);
    settle_check();
    chk("t6_relock", int'(o_locked), 1);

    // Randomized segments.
    for (int s = 0; s < 60; s++) begin
      p = int'($urandom_range(10, 2));
      h = ($urandom_range(1, 0) == 0) ? p / 2 : int'($urandom_range(p - 1, 1));
      n = int'($urandom_range(8, 1));
      r = ($urandom_range(3, 0) != 0) ? p : int'($urandom_range(12, 0));
      ratio = 4'(r);
      en = ($urandom_range(9, 0) != 0);
      if ($urandom_range(5, 0) == 0) hold(1'($urandom_range(1, 0)), int'($urandom_range(40, 5)));
      else run_clk(p, h, n);
      if ($urandom_range(19, 0) == 0) begin
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
    end
    hold(1'b0, 4);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
